// File: rtl/dcache_req_ctrl_if.sv
// dcache_req_ctrl_if: pipeline-side request, dcache bus and response signals of dcache_req_ctrl.
interface dcache_req_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] ctr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        flush;
    logic        llbit_clear;
    logic        dc_valid;
    logic        dc_ready;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [3:0]  dc_wstrb;
    logic [31:0] dc_wdata;
    logic        dc_rvalid;
    logic [31:0] dc_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_ale;
    logic        stall;
    logic        llbit;

    modport master (
        output req_valid, ctr, addr, wdata, flush, llbit_clear, dc_ready, dc_rvalid, dc_rdata,
        input  req_ready, dc_valid, dc_we, dc_addr, dc_wstrb, dc_wdata,
               resp_valid, resp_data, resp_ale, stall, llbit
    );

    modport slave (
        input  req_valid, ctr, addr, wdata, flush, llbit_clear, dc_ready, dc_rvalid, dc_rdata,
        output req_ready, dc_valid, dc_we, dc_addr, dc_wstrb, dc_wdata,
               resp_valid, resp_data, resp_ale, stall, llbit
    );
endinterface

// File: rtl/dcache_req_ctrl.sv
// dcache_req_ctrl: sequences exe1 memory ops onto the single-port dcache, owns the LLbit.
module dcache_req_ctrl (
    input logic clk,
    input logic rstn,
    dcache_req_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} state_t;
    state_t state;
    logic [3:0] typ;
    logic [4:0] sub;
    logic is_mem, is_ll, is_sc, is_st, is_b, is_h, mis, sc_fail;
    logic [3:0] strb;
    logic [31:0] wd, ld;
    logic [7:0] rbyte;
    logic [15:0] rhalf;
    logic r_ll, r_sc, r_b, r_h, r_sx;
    logic [1:0] r_lo;

    always_comb begin
        typ = bus.ctr[3:0];
        sub = bus.ctr[11:7];
        is_mem = (typ == 4'd5 && sub[4:3] == 2'b0) || (typ == 4'd6 && sub[4:1] == 4'b0);
        is_ll = typ == 4'd6 && sub == 5'd0;
        is_sc = typ == 4'd6 && sub == 5'd1;
        is_b = typ == 4'd5 && (sub == 5'd0 || sub == 5'd3 || sub == 5'd6);
        is_h = typ == 4'd5 && (sub == 5'd1 || sub == 5'd4 || sub == 5'd7);
        is_st = is_sc || (typ == 4'd5 && (sub == 5'd3 || sub == 5'd4 || sub == 5'd5));
        mis = is_h ? bus.addr[0] : !is_b && bus.addr[1:0] != 2'b0;
        sc_fail = is_sc && !bus.llbit && !mis;
        strb = is_b ? 4'b0001 << bus.addr[1:0] : is_h ? 4'b0011 << {bus.addr[1], 1'b0} : 4'b1111;
        wd = is_b ? {4{bus.wdata[7:0]}} : is_h ? {2{bus.wdata[15:0]}} : bus.wdata;
        rbyte = bus.dc_rdata[{r_lo, 3'b000} +: 8];
        rhalf = r_lo[1] ? bus.dc_rdata[31:16] : bus.dc_rdata[15:0];
        ld = r_b ? {{24{r_sx & rbyte[7]}}, rbyte} : r_h ? {{16{r_sx & rhalf[15]}}, rhalf} : bus.dc_rdata;
    end

    assign bus.req_ready = state == IDLE;
    assign bus.stall = state != IDLE;
    assign bus.resp_valid = state == RESP && !bus.flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            bus.dc_valid <= 1'b0;
            bus.dc_we <= 1'b0;
            bus.dc_addr <= 32'b0;
            bus.dc_wstrb <= 4'b0;
            bus.dc_wdata <= 32'b0;
            bus.resp_data <= 32'b0;
            bus.resp_ale <= 1'b0;
            bus.llbit <= 1'b0;
            {r_ll, r_sc, r_b, r_h, r_sx, r_lo} <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid && is_mem) begin
                    {r_ll, r_sc, r_b, r_h, r_sx, r_lo} <= {is_ll, is_sc, is_b, is_h,
                        typ == 4'd5 && sub <= 5'd1, bus.addr[1:0]};
                    bus.dc_addr <= {bus.addr[31:2], 2'b00};
                    bus.dc_we <= is_st;
                    bus.dc_wstrb <= is_st ? strb : 4'b0;
                    bus.dc_wdata <= wd;
                    bus.resp_ale <= mis;
                    bus.resp_data <= 32'b0;
                    bus.dc_valid <= !(mis || sc_fail);
                    state <= (mis || sc_fail) ? RESP : REQ;
                end
                REQ: if (bus.dc_ready) begin
                    bus.dc_valid <= 1'b0;
                    bus.resp_data <= {31'b0, r_sc};
                    state <= bus.dc_we ? (bus.flush ? IDLE : RESP) : (bus.flush ? DRAIN : WAIT);
                end else if (bus.flush) begin
                    bus.dc_valid <= 1'b0;
                    state <= IDLE;
                end
                // a flush landing with the returning data has nothing left to drain
                WAIT: if (bus.dc_rvalid) begin
                    bus.resp_data <= ld;
                    state <= bus.flush ? IDLE : RESP;
                end else if (bus.flush) state <= DRAIN;
                RESP: state <= IDLE;
                DRAIN: if (bus.dc_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
            bus.llbit <= !bus.llbit_clear && ((state == RESP && !bus.flush && !bus.resp_ale && (r_ll || r_sc))
                ? r_ll : bus.llbit);
        end
    end
endmodule

// File: tb/tb_dcache_req_ctrl.sv
// tb_dcache_req_ctrl: randomized ops against a transaction-timing model of the request controller.
module tb_dcache_req_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    dcache_req_ctrl_if bus();
    dcache_req_ctrl dut (.clk(clk), .rstn(rstn), .bus(bus.slave));
    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0, m_llbit = 1'b0;
    bit e_ready, e_stall, e_dcv, e_we, e_resp, e_ale, e_dchk;
    logic [31:0] e_addr, e_wdata, e_data, last_rd;
    logic [3:0] e_strb;
    logic last_ale;
    int size_of[8] = '{1, 2, 4, 1, 2, 4, 1, 2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.resp_valid) begin
            last_rd = bus.resp_data;
            last_ale = bus.resp_ale;
        end
        if (chk_en) begin
            chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
            chk("stall", 32'(bus.stall), 32'(e_stall));
            chk("dc_valid", 32'(bus.dc_valid), 32'(e_dcv));
            chk("resp_valid", 32'(bus.resp_valid), 32'(e_resp));
            chk("llbit", 32'(bus.llbit), 32'(m_llbit));
            if (e_dcv) begin
                chk("dc_addr", bus.dc_addr, e_addr);
                chk("dc_we", 32'(bus.dc_we), 32'(e_we));
                chk("dc_wstrb", 32'(bus.dc_wstrb), 32'(e_strb));
                if (e_we) chk("dc_wdata", bus.dc_wdata, e_wdata);
            end
            if (e_resp) begin
                chk("resp_ale", 32'(bus.resp_ale), 32'(e_ale));
                if (e_dchk) chk("resp_data", bus.resp_data, e_data);
            end
        end
    end

    task automatic tick(input bit clr, input bit com, input bit cval);
        @(posedge clk);
        m_llbit = clr ? 1'b0 : com ? cval : m_llbit;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            bit clr;
            clr = $urandom_range(0, 7) == 0;
            bus.req_valid = 1'b0;
            bus.flush = 1'($urandom);
            bus.llbit_clear = clr;
            bus.dc_ready = 1'($urandom);
            bus.dc_rvalid = 1'($urandom);
            bus.dc_rdata = $urandom;
            {e_ready, e_stall, e_dcv, e_resp} = 4'b1000;
            tick(clr, 1'b0, 1'b0);
        end
    endtask

    // d: cycles dc_ready stays low in REQ; e: cycles between handshake and rvalid
    task automatic run_op(input logic [3:0] typ, input logic [4:0] sub, input logic [31:0] a, wd, rd,
                          input int d, e, fl_at, clr_at);
        int sz, hs, rv, rsp, fin, dcv_last;
        bit ok, ll, sc, st, mis, scf, early, resp_on, load_hs;
        logic [31:0] mask, raw;
        ok = (typ == 4'd5 && sub < 5'd8) || (typ == 4'd6 && sub < 5'd2);
        ll = typ == 4'd6 && sub == 5'd0;
        sc = typ == 4'd6 && sub == 5'd1;
        st = sc || (typ == 4'd5 && sub >= 5'd3 && sub <= 5'd5);
        sz = (typ == 4'd5 && sub < 5'd8) ? size_of[sub[2:0]] : 4;
        mis = ok && (a % sz) != 0;
        scf = sc && !mis && !m_llbit;
        hs = 1 + d;
        rv = hs + 1 + e;
        early = fl_at >= 1 && fl_at < hs;
        if (!ok) begin rsp = -1; fin = 1; end
        else if (mis || scf) begin rsp = 1; fin = 2; end
        else if (early) begin rsp = -1; fin = fl_at + 1; end
        else if (st) begin rsp = fl_at == hs ? -1 : hs + 1; fin = fl_at == hs ? hs + 1 : hs + 2; end
        else begin rsp = (fl_at >= hs && fl_at <= rv) ? -1 : rv + 1; fin = rsp < 0 ? rv + 1 : rv + 2; end
        dcv_last = (!ok || mis || scf) ? 0 : early ? fl_at : hs;
        load_hs = dcv_last == hs && !st;
        resp_on = rsp > 0 && fl_at != rsp;
        mask = sz == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
        raw = (rd >> (8 * (a % 4))) & mask;
        if (typ == 4'd5 && sub < 5'd2 && raw[8 * sz - 1]) raw = raw | ~mask;
        e_addr = {a[31:2], 2'b00};
        e_we = st;
        e_strb = st ? 4'((1 << sz) - 1) << a[1:0] : 4'b0;
        e_wdata = sz == 1 ? wd[7:0] * 32'h0101_0101 : sz == 2 ? wd[15:0] * 32'h0001_0001 : wd;
        e_data = (mis || scf) ? 32'd0 : sc ? 32'd1 : raw;
        e_dchk = !st || sc || mis;
        e_ale = mis;
        for (int k = 0; k < fin; k++) begin
            bus.req_valid = k == 0 ? 1'b1 : 1'($urandom);
            bus.ctr = k == 0 ? {20'($urandom), sub, 3'($urandom), typ} : $urandom;
            bus.addr = k == 0 ? a : $urandom;
            bus.wdata = k == 0 ? wd : $urandom;
            bus.flush = k == fl_at;
            bus.llbit_clear = k == clr_at;
            bus.dc_ready = (k >= 1 && k <= dcv_last) ? k == hs : 1'($urandom);
            bus.dc_rvalid = (load_hs && k > hs && k <= rv) ? k == rv : 1'($urandom);
            bus.dc_rdata = k == rv ? rd : $urandom;
            e_ready = k == 0;
            e_stall = k > 0;
            e_dcv = k >= 1 && k <= dcv_last;
            e_resp = resp_on && k == rsp;
            tick(k == clr_at, resp_on && k == rsp && !mis && (ll || sc), ll);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.ctr = 32'b0;
        bus.addr = 32'b0;
        bus.wdata = 32'b0;
        bus.flush = 1'b0;
        bus.llbit_clear = 1'b0;
        bus.dc_ready = 1'b0;
        bus.dc_rvalid = 1'b0;
        bus.dc_rdata = 32'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_dc_valid", 32'(bus.dc_valid), 32'd0);
        chk("rst_dc_we", 32'(bus.dc_we), 32'd0);
        chk("rst_dc_wstrb", 32'(bus.dc_wstrb), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_resp_ale", 32'(bus.resp_ale), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_llbit", 32'(bus.llbit), 32'd0);
        rstn = 1'b1;
        chk_en = 1'b1;
        idle(2);
        run_op(4'd5, 5'd0, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0, -1, -1);
        chk("ldb_lit", last_rd, 32'hFFFF_FF80);
        run_op(4'd5, 5'd6, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0, -1, -1);
        chk("ldbu_lit", last_rd, 32'h0000_0080);
        run_op(4'd5, 5'd4, 32'h2002, 32'h1234_ABCD, 32'h0, 3, 0, -1, -1);
        run_op(4'd5, 5'd2, 32'h3001, 32'h0, 32'h0, 0, 0, -1, -1);
        chk("ale_lit", 32'(last_ale), 32'd1);
        run_op(4'd6, 5'd0, 32'h4000, 32'h0, 32'hDEAD_BEEF, 0, 0, -1, -1);
        chk("ll_set_lit", 32'(bus.llbit), 32'd1);
        run_op(4'd6, 5'd1, 32'h4000, 32'h5555_AAAA, 32'h0, 0, 0, -1, -1);
        chk("sc_ok_lit", last_rd, 32'd1);
        chk("sc_clr_lit", 32'(bus.llbit), 32'd0);
        run_op(4'd6, 5'd1, 32'h4000, 32'h5555_AAAA, 32'h0, 0, 0, -1, -1);
        chk("sc_fail_lit", last_rd, 32'd0);
        run_op(4'd6, 5'd0, 32'h4000, 32'h0, 32'h0, 0, 0, -1, 3);
        chk("ll_clr_lit", 32'(bus.llbit), 32'd0);
        run_op(4'd5, 5'd2, 32'h5000, 32'h0, 32'h1111_2222, 0, 2, 2, -1);
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [3:0] typ;
            logic [4:0] sub;
            logic [31:0] a;
            r = $urandom_range(0, 99);
            typ = r < 80 ? 4'd5 : r < 97 ? 4'd6 : 4'($urandom);
            sub = typ == 4'd5 ? ($urandom_range(0, 19) == 0 ? 5'($urandom) : 5'($urandom_range(0, 7)))
                : typ == 4'd6 ? 5'($urandom_range(0, 2)) : 5'($urandom);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            idle($urandom_range(0, 2));
            run_op(typ, sub, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 4) == 0 ? $urandom_range(0, 8) : -1,
                   $urandom_range(0, 9) == 0 ? $urandom_range(0, 6) : -1);
        end
        run_op(4'd6, 5'd0, 32'h4000, 32'h0, 32'h0, 0, 0, -1, -1);
        chk_en = 1'b0;
        bus.req_valid = 1'b1;
        bus.ctr = {20'b0, 5'd2, 3'b0, 4'd5};
        bus.addr = 32'h6000;
        bus.flush = 1'b0;
        bus.llbit_clear = 1'b0;
        bus.dc_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("pre_rst_dc_valid", 32'(bus.dc_valid), 32'd1);
        chk("pre_rst_llbit", 32'(bus.llbit), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(bus.stall), 32'd0);
        chk("mid_rst_dc_valid", 32'(bus.dc_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("mid_rst_llbit", 32'(bus.llbit), 32'd0);
        m_llbit = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        chk_en = 1'b1;
        idle(3);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
